fixed_predictor: RTL and testbench

Reconstructs PCM samples for one FLAC subframe that uses a FIXED predictor (order 0–4). Sits directly downstream of the Rice residual decoder (`resDecode`):
- consumes its `oMSB`/`oLSB`/`oDone` triplets;
- folds each triplet into a signed residual;
- adds the residual to the fixed-polynomial prediction from the sample history.

Warm-up (verbatim) samples come from the subframe header parser. Outputs are one reconstructed sample per accepted input, in stream order.

---
 rtl/flac_pkg.sv | 16 +
 rtl/residual_unfold.sv | 19 +
 rtl/fixed_predictor.sv | 166 ++++++++++++++++
 tb/tb_fixed_predictor.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flac_pkg.sv
// Shared definitions for the FLAC subframe reconstruction blocks.
package flac_pkg;

    // Predictor sequencing states
    typedef enum logic [1:0] {
        StIdle,
        StWarmup,
        StResid
    } state_e;

    localparam int unsigned MAX_FIXED_ORDER = 4;

    // Extra headroom bits for the prediction sum (coefficients up to 4+6+4+1 = 15)
    localparam int unsigned PRED_GUARD_BITS = 4;

endpackage

// File: rtl/residual_unfold.sv
// Combinational Rice fold (quotient/remainder) plus zigzag unfold to a signed residual.
module residual_unfold (
    input  logic [15:0]        msb,
    input  logic [15:0]        lsb,
    input  logic [3:0]         rice_param,
    output logic signed [31:0] residual
);

    logic [15:0] lsb_mask;
    logic [31:0] folded;

    // Fold quotient and masked remainder, then map zigzag code back to signed
    always_comb begin
        lsb_mask = (16'd1 << rice_param) - 16'd1;
        folded   = ({16'd0, msb} << rice_param) | {16'd0, lsb & lsb_mask};
        residual = signed'((folded >> 1) ^ {32{folded[0]}});
    end

endmodule

// File: rtl/fixed_predictor.sv
// FLAC FIXED-predictor sample reconstruction: warm-up pass-through, then
// polynomial prediction plus unfolded Rice residual, one sample per input.
module fixed_predictor
    import flac_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int BLOCK_W  = 16
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iStart,
    input  logic [2:0]          iOrder,
    input  logic [BLOCK_W-1:0]  iBlockSize,
    input  logic [SAMPLE_W-1:0] iWarmup,
    input  logic                iWarmupValid,
    input  logic [15:0]         iMSB,
    input  logic [15:0]         iLSB,
    input  logic [3:0]          iRiceParam,
    input  logic                iResValid,
    output logic [SAMPLE_W-1:0] oSample,
    output logic                oValid,
    output logic                oBlockDone,
    output logic                oBusy,
    output logic                oError
);

    localparam int PW = SAMPLE_W + PRED_GUARD_BITS;

    state_e state_q, state_d;
    logic [2:0]                order_q;
    logic [BLOCK_W-1:0]        blk_q;
    logic [BLOCK_W-1:0]        cnt_q, cnt_d, cnt_inc;
    logic signed [SAMPLE_W-1:0] h1_q, h2_q, h3_q, h4_q;
    logic [SAMPLE_W-1:0]       sample_q, sample_d;
    logic                      valid_d, done_q, done_d, err_q, err_d, valid_q;

    logic start_legal, start_ok, start_bad;
    logic warm_fire, res_fire, emit, last, warm_end;

    logic signed [31:0]   residual;
    logic signed [PW-1:0] x1, x2, x3, x4, pred;
    logic signed [31:0]   sum;
    logic                 unused_sum_hi;

    residual_unfold u_unfold (
        .msb        (iMSB),
        .lsb        (iLSB),
        .rice_param (iRiceParam),
        .residual   (residual)
    );

    // Decode the per-cycle events that drive state, counter and outputs
    always_comb begin
        start_legal = ({29'd0, iOrder} <= MAX_FIXED_ORDER) && (iBlockSize != '0)
                      && (iBlockSize >= BLOCK_W'(iOrder));
        start_ok    = iStart && (state_q == StIdle) && start_legal;
        start_bad   = iStart && (state_q == StIdle) && !start_legal;
        warm_fire   = (state_q == StWarmup) && iWarmupValid;
        res_fire    = (state_q == StResid) && iResValid;
        emit        = warm_fire || res_fire;
        cnt_inc     = cnt_q + 1'b1;
        last        = emit && (cnt_inc == blk_q);
        warm_end    = warm_fire && (cnt_inc == BLOCK_W'(order_q));
    end

    // Fixed-polynomial prediction from the sample history
    always_comb begin
        x1 = PW'(h1_q);
        x2 = PW'(h2_q);
        x3 = PW'(h3_q);
        x4 = PW'(h4_q);
        unique case (order_q)
            3'd1:    pred = x1;
            3'd2:    pred = (x1 <<< 1) - x2;
            3'd3:    pred = x1 + (x1 <<< 1) - x2 - (x2 <<< 1) + x3;
            3'd4:    pred = (x1 <<< 2) - (x2 <<< 2) - (x2 <<< 1) + (x3 <<< 2) - x4;
            default: pred = '0;
        endcase
        sum = 32'(pred) + residual;
    end

    // Only the low SAMPLE_W bits survive; the wrap is intentional
    assign unused_sum_hi = ^sum[31:SAMPLE_W];

    // State register
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic; block end wins over the warm-up to residual hand-off
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) state_d = (iOrder == 3'd0) ? StResid : StWarmup;
            end
            StWarmup: begin
                if (last)          state_d = StIdle;
                else if (warm_end) state_d = StResid;
            end
            StResid: begin
                if (last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values for the registered outputs, counter and error flag
    always_comb begin
        sample_d = sample_q;
        if (warm_fire)     sample_d = iWarmup;
        else if (res_fire) sample_d = sum[SAMPLE_W-1:0];
        valid_d = emit;
        done_d  = last;
        err_d   = err_q;
        if (start_ok) err_d = 1'b0;
        else if (start_bad || ((state_q == StWarmup) && iResValid)) err_d = 1'b1;
        cnt_d = cnt_q;
        if (start_ok)  cnt_d = '0;
        else if (emit) cnt_d = cnt_inc;
    end

    // Output registers, block parameters and history shift register
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            sample_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            order_q  <= '0;
            blk_q    <= '0;
            h1_q     <= '0;
            h2_q     <= '0;
            h3_q     <= '0;
            h4_q     <= '0;
        end else begin
            sample_q <= sample_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            if (start_ok) begin
                order_q <= iOrder;
                blk_q   <= iBlockSize;
                h1_q    <= '0;
                h2_q    <= '0;
                h3_q    <= '0;
                h4_q    <= '0;
            end else if (emit) begin
                h1_q <= signed'(sample_d);
                h2_q <= h1_q;
                h3_q <= h2_q;
                h4_q <= h3_q;
            end
        end
    end

    assign oSample    = sample_q;
    assign oValid     = valid_q;
    assign oBlockDone = done_q;
    assign oError     = err_q;
    assign oBusy      = (state_q != StIdle);

endmodule

// File: tb/tb_fixed_predictor.sv
// Self-checking bench for fixed_predictor: directed cases then randomized blocks
// compared against an arithmetic reference model.
module tb_fixed_predictor;

    logic        iClk = 1'b0;
    logic        iRst = 1'b0;
    logic        iStart = 1'b0;
    logic [2:0]  iOrder = '0;
    logic [15:0] iBlockSize = '0;
    logic [15:0] iWarmup = '0;
    logic        iWarmupValid = 1'b0;
    logic [15:0] iMSB = '0;
    logic [15:0] iLSB = '0;
    logic [3:0]  iRiceParam = '0;
    logic        iResValid = 1'b0;
    logic [15:0] oSample;
    logic        oValid, oBlockDone, oBusy, oError;

    int tests = 0;
    int fails = 0;
    int hist[4];

    fixed_predictor #(.SAMPLE_W(16), .BLOCK_W(16)) dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .iStart       (iStart),
        .iOrder       (iOrder),
        .iBlockSize   (iBlockSize),
        .iWarmup      (iWarmup),
        .iWarmupValid (iWarmupValid),
        .iMSB         (iMSB),
        .iLSB         (iLSB),
        .iRiceParam   (iRiceParam),
        .iResValid    (iResValid),
        .oSample      (oSample),
        .oValid       (oValid),
        .oBlockDone   (oBlockDone),
        .oBusy        (oBusy),
        .oError       (oError)
    );

    initial forever #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int s, input bit v, input bit d);
        logic [15:0] e;
        e = 16'(s);
        chk({tag, ".sample"}, {16'd0, oSample}, {16'd0, e});
        chk({tag, ".valid"}, {31'd0, oValid}, {31'd0, v});
        chk({tag, ".done"}, {31'd0, oBlockDone}, {31'd0, d});
    endtask

    task automatic tick();
        @(negedge iClk);
    endtask

    task automatic start(input int ord, input int bs);
        iStart = 1'b1;
        iOrder = ord[2:0];
        iBlockSize = bs[15:0];
        tick();
        iStart = 1'b0;
    endtask

    task automatic warm(input int v);
        iWarmupValid = 1'b1;
        iWarmup = v[15:0];
        tick();
        iWarmupValid = 1'b0;
    endtask

    task automatic res(input int msb, input int lsb, input int k);
        iResValid = 1'b1;
        iMSB = msb[15:0];
        iLSB = lsb[15:0];
        iRiceParam = k[3:0];
        tick();
        iResValid = 1'b0;
    endtask

    // Reference model: binomial-coefficient predictor, arithmetic zigzag unfold
    function automatic int binom(input int n, input int r);
        int v = 1;
        for (int i = 0; i < r; i++) v = v * (n - i) / (i + 1);
        return v;
    endfunction

    function automatic longint model_pred(input int ord);
        longint p = 0;
        for (int j = 1; j <= ord; j++)
            p += ((j % 2 == 1) ? 1 : -1) * binom(ord, j) * hist[j-1];
        return p;
    endfunction

    function automatic longint model_resid(input int msb, input int lsb, input int k);
        longint u;
        u = longint'(msb) * (longint'(1) << k) + longint'(lsb % (1 << k));
        return (u % 2 == 0) ? u / 2 : -(u + 1) / 2;
    endfunction

    function automatic int wrap16(input longint v);
        shortint s;
        s = shortint'(v);
        return int'(s);
    endfunction

    task automatic model_push(input int s);
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = s;
    endtask

    initial begin
        int ord, bs, exp_s, msb, lsb, k, w;

        // Reset state
        #12;
        chk("rst.sample", {16'd0, oSample}, 32'd0);
        chk("rst.valid", {31'd0, oValid}, 32'd0);
        chk("rst.done", {31'd0, oBlockDone}, 32'd0);
        chk("rst.busy", {31'd0, oBusy}, 32'd0);
        chk("rst.error", {31'd0, oError}, 32'd0);
        @(negedge iClk);
        iRst = 1'b1;
        tick();

        // Inputs in IDLE are ignored
        res(1, 0, 0);
        chk("idle.valid", {31'd0, oValid}, 32'd0);

        // Order 0
        start(0, 2);
        chk("o0.busy", {31'd0, oBusy}, 32'd1);
        res(5, 6, 3);
        chk_out("o0.a", 23, 1, 0);
        res(5, 5, 3);
        chk_out("o0.b", -23, 1, 1);
        chk("o0.busy_end", {31'd0, oBusy}, 32'd0);

        // Order 2
        start(2, 4);
        warm(10);
        chk_out("o2.w0", 10, 1, 0);
        warm(20);
        chk_out("o2.w1", 20, 1, 0);
        res(0, 0, 0);
        chk_out("o2.r0", 30, 1, 0);
        res(3, 0, 0);
        chk_out("o2.r1", 38, 1, 1);

        // Order 1, block size 3, back-to-back start with the done cycle
        start(1, 3);
        warm(100);
        chk_out("o1.w0", 100, 1, 0);
        res(2, 0, 0);
        chk_out("o1.r0", 101, 1, 0);
        res(1, 0, 0);
        chk_out("o1.r1", 100, 1, 1);
        start(1, 2);
        chk("b2b.busy", {31'd0, oBusy}, 32'd1);

        // Wrap
        warm(32767);
        chk_out("wrap.w0", 32767, 1, 0);
        res(2, 0, 0);
        chk_out("wrap.r0", -32768, 1, 1);

        // Errors
        start(5, 4);
        chk("err.order.error", {31'd0, oError}, 32'd1);
        chk("err.order.busy", {31'd0, oBusy}, 32'd0);
        start(1, 3);
        chk("err.clear", {31'd0, oError}, 32'd0);
        res(0, 0, 0);
        chk("err.reswarm.error", {31'd0, oError}, 32'd1);
        chk("err.reswarm.valid", {31'd0, oValid}, 32'd0);
        warm(5);
        chk_out("err.w0", 5, 1, 0);
        res(0, 0, 0);
        res(0, 0, 0);
        chk_out("err.r1", 5, 1, 1);
        chk("err.sticky", {31'd0, oError}, 32'd1);
        start(3, 2);
        chk("err.bs_lt_order", {31'd0, oError}, 32'd1);
        chk("err.bs_lt_order.busy", {31'd0, oBusy}, 32'd0);
        start(0, 0);
        chk("err.bs_zero", {31'd0, oError}, 32'd1);
        start(4, 4);
        chk("err.clear2", {31'd0, oError}, 32'd0);
        for (int i = 0; i < 4; i++) warm(i + 1);
        chk_out("err.o4_warm_only", 4, 1, 1);

        // Reset mid-block
        start(0, 5);
        res(6, 0, 0);
        chk_out("rstm.r0", 3, 1, 0);
        #2;
        iRst = 1'b0;
        #1;
        chk("rstm.sample", {16'd0, oSample}, 32'd0);
        chk("rstm.valid", {31'd0, oValid}, 32'd0);
        chk("rstm.busy", {31'd0, oBusy}, 32'd0);
        chk("rstm.error", {31'd0, oError}, 32'd0);
        @(negedge iClk);
        iRst = 1'b1;
        res(4, 0, 0);
        chk("rstm.no_out", {31'd0, oValid}, 32'd0);
        start(0, 1);
        res(4, 0, 0);
        chk_out("rstm.fresh", 2, 1, 1);

        // Randomized blocks, sustained one input per cycle, junk strobes mixed in
        for (int b = 0; b < 25; b++) begin
            ord = $urandom_range(0, 4);
            bs  = $urandom_range((ord == 0) ? 1 : ord, ord + 10);
            for (int j = 0; j < 4; j++) hist[j] = 0;
            start(ord, bs);
            chk("rnd.busy", {31'd0, oBusy}, 32'd1);
            for (int i = 0; i < bs; i++) begin
                iStart = ($urandom_range(0, 3) == 0);
                iOrder = 3'($urandom_range(0, 7));
                if (i < ord) begin
                    w = $urandom_range(0, 65535);
                    iWarmupValid = 1'b1;
                    iWarmup = w[15:0];
                    iResValid = 1'b0;
                    exp_s = wrap16(longint'(w));
                end else begin
                    msb = $urandom_range(0, 40);
                    lsb = $urandom_range(0, 65535);
                    k   = $urandom_range(0, 15);
                    iResValid = 1'b1;
                    iMSB = msb[15:0];
                    iLSB = lsb[15:0];
                    iRiceParam = k[3:0];
                    iWarmupValid = ($urandom_range(0, 1) == 1);
                    iWarmup = 16'($urandom);
                    exp_s = wrap16(model_pred(ord) + model_resid(msb, lsb, k));
                end
                tick();
                model_push(exp_s);
                chk_out($sformatf("rnd%0d.s%0d", b, i), exp_s, 1, (i == bs - 1));
            end
            iStart = 1'b0;
            iWarmupValid = 1'b0;
            iResValid = 1'b0;
            chk("rnd.idle_busy", {31'd0, oBusy}, 32'd0);
            chk("rnd.error", {31'd0, oError}, 32'd0);
            tick();
            chk("rnd.quiet", {31'd0, oValid}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
